rf_access_arbiter: RTL and testbench



---
 rtl/rf_arb_pkg.sv | 15 +
 rtl/rf_arb_timer.sv | 34 +++
 rtl/rf_access_arbiter.sv | 137 +++++++++++++
 tb/tb_rf_access_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
// Shared definitions for the register-file access arbiter: FSM state
// encoding and requester index constants.
package rf_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam logic REQ_CTRL = 1'b0;
  localparam logic REQ_CFG  = 1'b1;

endpackage

// File: rtl/rf_arb_timer.sv
// Clearable up-counter used to bound read waits; tc_o flags TIMEOUT-1.
module rf_arb_timer #(
  parameter int unsigned TIMEOUT  = 15,
  parameter int unsigned TO_WIDTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [TO_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + TO_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TO_WIDTH'(TIMEOUT - 1));

endmodule

// File: rtl/rf_access_arbiter.sv
// Round-robin arbiter sharing one register-file port between the controller
// command path (port 0) and the configuration/debug master (port 1).
module rf_access_arbiter
  import rf_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned TIMEOUT    = 15,
  parameter int unsigned TO_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic                  err0,
  output logic                  err1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  output logic                  rf_wr_en,
  output logic                  rf_rd_en,
  output logic [DATA_WIDTH-1:0] rf_wr_data,
  input  logic [DATA_WIDTH-1:0] rf_rd_data,
  input  logic                  rf_rd_data_valid,
  output logic                  busy
);

  state_e                state_q;
  logic                  idx_q, we_q, ptr_q, err_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata0_q, rdata1_q;
  logic                  grant_valid, grant_idx;
  logic                  tmr_clr, tmr_en, tmr_tc;

  always_comb begin
    grant_valid = req0 | req1;
    grant_idx   = REQ_CTRL;
    if (req0 && req1) begin
      grant_idx = ptr_q;
    end else if (req1) begin
      grant_idx = REQ_CFG;
    end
  end

  assign tmr_clr = (state_q == ISSUE);
  assign tmr_en  = (state_q == RD_WAIT) && !rf_rd_data_valid && !tmr_tc;

  rf_arb_timer #(
    .TIMEOUT (TIMEOUT),
    .TO_WIDTH(TO_WIDTH)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr_i(tmr_clr),
    .en_i (tmr_en),
    .tc_o (tmr_tc)
  );

  // Read results land in the served port's register on entry to DONE so that
  // rdata is already valid in the ack cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= REQ_CTRL;
      we_q     <= 1'b0;
      ptr_q    <= REQ_CTRL;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant_valid) begin
            idx_q   <= grant_idx;
            we_q    <= (grant_idx == REQ_CFG) ? we1 : we0;
            addr_q  <= (grant_idx == REQ_CFG) ? addr1 : addr0;
            wdata_q <= (grant_idx == REQ_CFG) ? wdata1 : wdata0;
            err_q   <= 1'b0;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (we_q) begin
            state_q <= DONE;
          end else if (rf_rd_data_valid) begin
            if (idx_q == REQ_CFG) rdata1_q <= rf_rd_data;
            else                  rdata0_q <= rf_rd_data;
            err_q   <= 1'b0;
            state_q <= DONE;
          end else begin
            state_q <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (rf_rd_data_valid) begin
            if (idx_q == REQ_CFG) rdata1_q <= rf_rd_data;
            else                  rdata0_q <= rf_rd_data;
            err_q   <= 1'b0;
            state_q <= DONE;
          end else if (tmr_tc) begin
            if (idx_q == REQ_CFG) rdata1_q <= '0;
            else                  rdata0_q <= '0;
            err_q   <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          ptr_q   <= ~idx_q;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy       = (state_q != IDLE);
  assign rf_wr_en   = (state_q == ISSUE) && we_q;
  assign rf_rd_en   = ((state_q == ISSUE) && !we_q) || (state_q == RD_WAIT);
  assign rf_addr    = (rf_wr_en || rf_rd_en) ? addr_q : '0;
  assign rf_wr_data = rf_wr_en ? wdata_q : '0;
  assign ack0       = (state_q == DONE) && (idx_q == REQ_CTRL);
  assign ack1       = (state_q == DONE) && (idx_q == REQ_CFG);
  assign err0       = ack0 && err_q;
  assign err1       = ack1 && err_q;
  assign rdata0     = rdata0_q;
  assign rdata1     = rdata1_q;

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Directed bench for rf_access_arbiter: writes, reads, contention, timeout,
// reset mid-read, fairness and single-requester back-to-back service.
module tb_rf_access_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1, we0, we1;
  logic [3:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       ack0, ack1, err0, err1;
  logic [7:0] rdata0, rdata1;
  logic [3:0] rf_addr;
  logic       rf_wr_en, rf_rd_en;
  logic [7:0] rf_wr_data, rf_rd_data;
  logic       rf_rd_data_valid, busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rf_access_arbiter #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4),
    .TIMEOUT   (15),
    .TO_WIDTH  (4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req0            (req0),
    .req1            (req1),
    .we0             (we0),
    .we1             (we1),
    .addr0           (addr0),
    .addr1           (addr1),
    .wdata0          (wdata0),
    .wdata1          (wdata1),
    .ack0            (ack0),
    .ack1            (ack1),
    .err0            (err0),
    .err1            (err1),
    .rdata0          (rdata0),
    .rdata1          (rdata1),
    .rf_addr         (rf_addr),
    .rf_wr_en        (rf_wr_en),
    .rf_rd_en        (rf_rd_en),
    .rf_wr_data      (rf_wr_data),
    .rf_rd_data      (rf_rd_data),
    .rf_rd_data_valid(rf_rd_data_valid),
    .busy            (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    rf_rd_data = 0; rf_rd_data_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({ack0, ack1, err0, err1, busy, rf_wr_en, rf_rd_en} !== 7'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b want 0000000",
               {ack0, ack1, err0, err1, busy, rf_wr_en, rf_rd_en});
    end
    tests++;
    if ({rf_addr, rf_wr_data, rdata0, rdata1} !== 28'h0) begin
      fails++;
      $display("FAIL reset_data: got %h want 0", {rf_addr, rf_wr_data, rdata0, rdata1});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_p0();
    req0 = 1; we0 = 1; addr0 = 4'h3; wdata0 = 8'h5A;
    tests++;
    if (rf_wr_en !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL wr_cycleN: wr_en=%b busy=%b want 0 0", rf_wr_en, busy);
    end
    tick();
    tests++;
    if (rf_wr_en !== 1'b1 || rf_addr !== 4'h3 || rf_wr_data !== 8'h5A || busy !== 1'b1
        || ack0 !== 1'b0) begin
      fails++;
      $display("FAIL wr_strobe: wr_en=%b addr=%h data=%h busy=%b ack0=%b want 1 3 5a 1 0",
               rf_wr_en, rf_addr, rf_wr_data, busy, ack0);
    end
    tick();
    tests++;
    if (ack0 !== 1'b1 || err0 !== 1'b0 || ack1 !== 1'b0 || rf_wr_en !== 1'b0
        || rf_wr_data !== 8'h00 || busy !== 1'b1) begin
      fails++;
      $display("FAIL wr_ack: ack0=%b err0=%b ack1=%b wr_en=%b data=%h busy=%b want 1 0 0 0 00 1",
               ack0, err0, ack1, rf_wr_en, rf_wr_data, busy);
    end
    req0 = 0;
    tick();
    tests++;
    if (ack0 !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL wr_idle: ack0=%b busy=%b want 0 0", ack0, busy);
    end
  endtask

  task automatic test_read_p1();
    int rd_cycles = 0;
    req1 = 1; we1 = 0; addr1 = 4'h7;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (rf_rd_en && rf_addr == 4'h7 && !ack0 && !ack1) rd_cycles++;
      if (i == 2) begin
        rf_rd_data_valid = 1; rf_rd_data = 8'hC3;
      end
    end
    tick();
    rf_rd_data_valid = 0; rf_rd_data = 8'h00;
    tests++;
    if (rd_cycles != 3) begin
      fails++;
      $display("FAIL rd_en_len: got %0d cycles want 3", rd_cycles);
    end
    tests++;
    if (ack1 !== 1'b1 || rdata1 !== 8'hC3 || err1 !== 1'b0 || ack0 !== 1'b0
        || rf_rd_en !== 1'b0 || rdata0 !== 8'h00) begin
      fails++;
      $display("FAIL rd_ack: ack1=%b rdata1=%h err1=%b ack0=%b rd_en=%b rdata0=%h want 1 c3 0 0 0 00",
               ack1, rdata1, err1, ack0, rf_rd_en, rdata0);
    end
    req1 = 0;
    tick();
  endtask

  task automatic test_contention(input string name);
    int order[$];
    int t0 = -1;
    int t1 = -1;
    req0 = 1; we0 = 0; addr0 = 4'h1;
    req1 = 1; we1 = 0; addr1 = 4'h2;
    for (int i = 0; i < 20 && (req0 || req1); i++) begin
      tick();
      rf_rd_data_valid = rf_rd_en;
      rf_rd_data = {4'hA, rf_addr};
      if (ack0) begin order.push_back(0); t0 = i; req0 = 0; end
      if (ack1) begin order.push_back(1); t1 = i; req1 = 0; end
    end
    rf_rd_data_valid = 0;
    tests++;
    if (order.size() != 2 || order[0] != 0 || order[1] != 1) begin
      fails++;
      $display("FAIL %s_order: got %0d acks (first=%0d) want port0 then port1", name,
               order.size(), (order.size() > 0) ? order[0] : -1);
    end
    tests++;
    if (t0 != 1 || t1 != 4) begin
      fails++;
      $display("FAIL %s_timing: ack0 at %0d ack1 at %0d want 1 and 4", name, t0, t1);
    end
    tests++;
    if (rdata0 !== 8'hA1 || rdata1 !== 8'hA2) begin
      fails++;
      $display("FAIL %s_data: rdata0=%h rdata1=%h want a1 a2", name, rdata0, rdata1);
    end
    tick();
  endtask

  task automatic test_timeout();
    int rd_cycles = 0;
    int i1 = -1;
    logic got = 0;
    logic early1 = 0;
    req0 = 1; we0 = 0; addr0 = 4'h4;
    req1 = 1; we1 = 0; addr1 = 4'h6;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      if (rf_rd_en) rd_cycles++;
      if (ack1) early1 = 1;
      if (ack0) got = 1;
    end
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL to_ack_budget: no ack0 within 40 cycles");
    end
    tests++;
    if (rd_cycles != 16) begin
      fails++;
      $display("FAIL to_rd_len: got %0d cycles want 16", rd_cycles);
    end
    tests++;
    if (ack0 !== 1'b1 || err0 !== 1'b1 || rdata0 !== 8'h00 || early1) begin
      fails++;
      $display("FAIL to_result: ack0=%b err0=%b rdata0=%h ack1_seen=%b want 1 1 00 0",
               ack0, err0, rdata0, early1);
    end
    req0 = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      rf_rd_data_valid = rf_rd_en;
      rf_rd_data = 8'h5C;
      if (ack1) begin i1 = i; break; end
    end
    rf_rd_data_valid = 0;
    tests++;
    if (i1 != 2 || err1 !== 1'b0 || rdata1 !== 8'h5C || rdata0 !== 8'h00) begin
      fails++;
      $display("FAIL to_next_p1: ack1 at %0d err1=%b rdata1=%h rdata0=%h want 2 0 5c 00",
               i1, err1, rdata1, rdata0);
    end
    req1 = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    logic stray = 0;
    int first = -1;
    // Serve port 0 so the pointer favours port 1 before the reset.
    req0 = 1; we0 = 1; addr0 = 4'h5; wdata0 = 8'h11;
    for (int i = 0; i < 6 && req0; i++) begin
      tick();
      if (ack0) req0 = 0;
    end
    tick();
    req1 = 1; we1 = 0; addr1 = 4'h9;
    repeat (4) tick();
    rst_n = 0;
    #1;
    tests++;
    if ({rf_rd_en, rf_wr_en, busy, ack0, ack1} !== 5'b0 || rf_addr !== 4'h0
        || rdata1 !== 8'h00) begin
      fails++;
      $display("FAIL rstmid_outs: ctl=%b addr=%h rdata1=%h want 00000 0 00",
               {rf_rd_en, rf_wr_en, busy, ack0, ack1}, rf_addr, rdata1);
    end
    req1 = 0;
    repeat (2) tick();
    rst_n = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ack0 || ack1 || busy) stray = 1;
    end
    tests++;
    if (stray) begin
      fails++;
      $display("FAIL rstmid_noack: activity after reset release want none");
    end
    req0 = 1; we0 = 1; addr0 = 4'h2; wdata0 = 8'h22;
    req1 = 1; we1 = 1; addr1 = 4'hB; wdata1 = 8'h33;
    for (int i = 0; i < 20 && (req0 || req1); i++) begin
      tick();
      if (ack0) begin if (first < 0) first = 0; req0 = 0; end
      if (ack1) begin if (first < 0) first = 1; req1 = 0; end
    end
    tests++;
    if (first != 0) begin
      fails++;
      $display("FAIL rstmid_ptr: first grant %0d want 0", first);
    end
    tick();
  endtask

  task automatic test_fairness();
    req0 = 1; we0 = 1; addr0 = 4'h1; wdata0 = 8'hA0;
    req1 = 1; we1 = 1; addr1 = 4'hE; wdata1 = 8'hB0;
    tick();
    tick();
    tests++;
    if (ack0 !== 1'b1) begin
      fails++;
      $display("FAIL fair_first: ack0=%b want 1", ack0);
    end
    req0 = 0;
    tick();
    req0 = 1; wdata0 = 8'hA5;
    tick();
    tests++;
    if (rf_wr_en !== 1'b1 || rf_addr !== 4'hE || rf_wr_data !== 8'hB0) begin
      fails++;
      $display("FAIL fair_second: wr_en=%b addr=%h data=%h want 1 e b0", rf_wr_en, rf_addr,
               rf_wr_data);
    end
    tick();
    tests++;
    if (ack1 !== 1'b1 || ack0 !== 1'b0) begin
      fails++;
      $display("FAIL fair_ack1: ack1=%b ack0=%b want 1 0", ack1, ack0);
    end
    req1 = 0;
    tick();
    tick();
    tests++;
    if (rf_wr_en !== 1'b1 || rf_addr !== 4'h1 || rf_wr_data !== 8'hA5) begin
      fails++;
      $display("FAIL fair_third: wr_en=%b addr=%h data=%h want 1 1 a5", rf_wr_en, rf_addr,
               rf_wr_data);
    end
    tick();
    req0 = 0;
    tick();
  endtask

  task automatic test_back_to_back();
    int acks[$];
    req1 = 1; we1 = 1; addr1 = 4'hC; wdata1 = 8'h77;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (ack1) acks.push_back(i);
    end
    req1 = 0;
    tests++;
    if (acks.size() != 3 || acks[0] != 1 || acks[1] != 4 || acks[2] != 7) begin
      fails++;
      $display("FAIL b2b_spacing: got %0d acks (first at %0d) want 3 at 1,4,7", acks.size(),
               (acks.size() > 0) ? acks[0] : -1);
    end
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_write_p0();
    test_read_p1();
    test_contention("cont1");
    test_contention("cont2");
    test_timeout();
    test_reset_mid();
    test_fairness();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
